// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: packs R/I/S/B/U/J instruction fields into 32-bit words and streams them to instruction memory.
// Defining ENC_RANGE_CHECK_EN rejects immediates that do not fit their format instead of truncating them.
module instr_encoder_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned MAX_INSTR = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_last,
  input  logic [2:0]  in_type,
  input  logic [2:0]  in_func3,
  input  logic [6:0]  in_func7,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [8:0]  count,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [8:0] MAX_CNT = 9'(MAX_INSTR);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] ptr_q, ptr_d;
  logic [8:0]  count_q, count_d;
  logic        err_q, err_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic [6:0]  op;
  logic [31:0] enc_word;
  logic        type_ok;
  logic        imm_ok;
  logic        accept;

  always_comb begin
    op       = {4'b0, in_type};
    enc_word = '0;
    type_ok  = 1'b1;
    case (in_type)
      3'd0: enc_word = {in_func7, in_rs2, in_rs1, in_func3, in_rd, op};
      3'd1: enc_word = {in_imm[11:0], in_rs1, in_func3, in_rd, op};
      3'd2: enc_word = {in_imm[11:5], in_rs2, in_rs1, in_func3, in_imm[4:0], op};
      3'd3: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_func3,
                        in_imm[4:1], in_imm[11], op};
      3'd4: enc_word = {in_imm[31:12], in_rd, op};
      3'd5: enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, op};
      default: type_ok = 1'b0;
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  // Immediate must sign-extend cleanly from its format width; branch/jump offsets must be even.
  always_comb begin
    imm_ok = 1'b1;
    case (in_type)
      3'd1, 3'd2: imm_ok = (in_imm[31:11] == {21{in_imm[11]}});
      3'd3:       imm_ok = (in_imm[31:12] == {20{in_imm[12]}}) && !in_imm[0];
      3'd4:       imm_ok = (in_imm[11:0] == 12'd0);
      3'd5:       imm_ok = (in_imm[31:20] == {12{in_imm[20]}}) && !in_imm[0];
      default:    imm_ok = 1'b1;
    endcase
  end
`else
  assign imm_ok = 1'b1;
`endif

  assign in_ready = (state_q == LOAD) && (count_q < MAX_CNT);
  assign accept   = in_valid && in_ready && !abort;

  // Encoded word is captured on accept, so the write strobe appears exactly one cycle later.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    err_d   = err_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = LOAD;
          ptr_d   = BASE_ADDR;
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = DONE;
        end else if (accept) begin
          if (type_ok && imm_ok) begin
            we_d    = 1'b1;
            addr_d  = ptr_q;
            wdata_d = enc_word;
            ptr_d   = ptr_q + 32'd4;
            count_d = count_q + 9'd1;
          end else begin
            err_d = 1'b1;
          end
          if (in_last || (count_d == MAX_CNT)) begin
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= BASE_ADDR;
      count_q <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign count     = count_q;
  assign busy      = (state_q == LOAD);
  assign done      = (state_q == DONE);
  assign err       = err_q;

endmodule
